fetch_line_unit: RTL
====================

Name: fetch_line_unit

Overview:
Front-end fetch stage directly upstream of the instruction cache. Generates line-aligned fetch addresses on the icache address channel and accepts returned lines (icache_out_t: pc + line[ICACHE_INSTR]) into a small line buffer. Hands single instructions with their PC to decode over a valid/ready interface. Supports redirect (flush) with discard of in-flight responses.

Parameters:
BOOT_PC, 32'h0000_0000, fetch PC after reset; low bits select the first instruction within its line.
LINE_BUF_DEPTH, 2, line buffer entries (power of 2, >=1).
MAX_OUTSTANDING, 2, maximum accepted-but-unreturned requests, including ones marked for drop.
Derived: LINE_BYTES = ICACHE_INSTR*4; OFF_W = log2(ICACHE_INSTR). XLEN and ICACHE_INSTR come from mmm_pkg.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  redirect request, sampled at posedge
flush_pc_i  in  XLEN  redirect target PC (4-byte aligned)
icache_addr_o  out  XLEN  line-aligned fetch address
icache_addr_valid_o  out  1  address request valid
icache_addr_ready_i  in  1  icache accepts address
icache_data_i  in  icache_out_t  returned line and its pc
icache_data_valid_i  in  1  returned line valid
icache_data_ready_o  out  1  unit accepts line
instr_o  out  32  instruction to decode
instr_pc_o  out  XLEN  PC of instr_o
instr_valid_o  out  1  instr_o/instr_pc_o valid
instr_ready_i  in  1  decode accepts instruction

Behaviour:
- Reset (async, immediate): icache_addr_valid_o=0, icache_data_ready_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- Reset internal state: fetch_addr = BOOT_PC with low log2(LINE_BYTES) bits cleared; start_idx = BOOT_PC[OFF_W+1:2]; outstanding=0; drop_cnt=0; buffer empty; rd_idx=0.
- First icache_addr_valid_o occurs in the first cycle after reset deasserts.
- Address channel: icache_addr_valid_o = (outstanding + drop_cnt < MAX_OUTSTANDING) && (outstanding + occupancy < LINE_BUF_DEPTH). This credit rule guarantees buffer space for every live response.
- icache_addr_o = fetch_addr.
- Address and valid stay stable while valid && !ready; they change only on a handshake, flush, or reset.
- Address handshake (valid && ready at posedge): fetch_addr += LINE_BYTES with modulo 2^XLEN wrap; outstanding++.
- Data channel: icache_data_ready_o = 1 whenever not in reset.
- Accepted beat with drop_cnt>0: beat discarded; drop_cnt--.
- Accepted beat with drop_cnt==0: push {line, pc, start_idx}; start_idx cleared to 0; outstanding--.
- A beat arriving with outstanding==drop_cnt==0 is a protocol error: flag with a simulation assertion and discard.
- Output: instr_valid_o = buffer non-empty.
- Output offset: cur = (rd_idx==0 ? head.start_idx : rd_idx).
- Output data: instr_o = head.line[cur]; instr_pc_o = head.pc + cur*4.
- Output is combinational from registered buffer state: zero extra latency. With a zero-delay icache, the first instruction is valid 2 cycles after the first address handshake.
- Instruction handshake: if cur == ICACHE_INSTR-1, pop head and set rd_idx=0; else rd_idx = cur+1.
- Simultaneous push and pop are allowed; occupancy is unchanged. Push into a full buffer cannot occur by credit.
- Flush (flush_i at posedge) has priority over every same-cycle event:
  - buffer emptied; rd_idx=0;
  - fetch_addr = flush_pc_i line-aligned; start_idx = flush_pc_i[OFF_W+1:2];
  - drop_cnt = drop_cnt + outstanding + (addr handshake this cycle), minus 1 if a beat is accepted this cycle and that sum is >0; outstanding=0.
  - A same-cycle instruction handshake is considered consumed by decode; it has no further effect.
  - instr_valid_o is 0 in the cycle after flush.
- Back-to-back flushes accumulate drop_cnt; the cap is MAX_OUTSTANDING.
- Reset mid-operation discards everything. A responder must also be reset; stale beats after reset are protocol errors.

Test Plan:
1. Reset, BOOT_PC=0, zero-delay icache returning line[i]=i+1, instr_ready_i=1 -> addrs 0x0,0x10,0x20...; instr_o 1,2,3,4,1,2... with instr_pc_o 0x0,0x4,0x8,0xC,0x10...; one instruction/cycle in steady state.
2. instr_ready_i=0 for 20 cycles from reset -> exactly 2 address handshakes (0x0,0x10), icache_addr_valid_o then 0; on release, 8 instructions pc 0x0..0x1C in order, none lost or duplicated.
3. icache_addr_ready_i held 0 for 5 cycles -> icache_addr_valid_o=1 and icache_addr_o=0x0 stable all 5 cycles; handshake on 6th; next addr 0x10.
4. Icache with 3-cycle data delay, flush_i with flush_pc_i=0x108 while 2 requests outstanding -> next addr 0x100; both stale lines dropped; first output pc 0x108 instr 3, then 0x10C instr 4, then 0x110 instr 1.
5. flush_i in same cycle as an accepted data beat and an addr handshake (outstanding=1) -> beat discarded; drop_cnt=1; next accepted beat also discarded; following line output normally.
6. rst_i asserted asynchronously mid-stream (between edges) -> all outputs 0 immediately; after release, fetch restarts at BOOT_PC line with correct start_idx.

Source files
------------

// File: rtl/fetch_line_unit.sv
// Fetch stage ahead of the instruction cache. It issues line-aligned fetch requests,
// buffers the returned lines, and hands instructions one at a time to decode.
package mmm_pkg;
    localparam int XLEN         = 32;
    localparam int ICACHE_INSTR = 4;

    typedef struct packed {
        logic [XLEN-1:0]                pc;
        logic [ICACHE_INSTR-1:0][31:0]  line;
    } icache_out_t;
endpackage

// Protocol checks for the fetch unit; simulation only.
module fetch_line_unit_chk #(
    parameter int CNT_W           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             beat_i,
    input logic [CNT_W-1:0] outst_i,
    input logic [CNT_W-1:0] drop_i
);
    stray_beat_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(beat_i && (outst_i == '0) && (drop_i == '0)))
        else $error("icache beat with no request outstanding");

    credit_cap_a: assert property (@(posedge clk_i) disable iff (rst_i)
        ((outst_i + drop_i) <= CNT_W'(MAX_OUTSTANDING)))
        else $error("outstanding plus dropped requests exceed cap");
endmodule

module fetch_line_unit
    import mmm_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_PC         = 32'h0000_0000,
    parameter int              LINE_BUF_DEPTH  = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   flush_pc_i,
    output logic [XLEN-1:0]   icache_addr_o,
    output logic              icache_addr_valid_o,
    input  logic              icache_addr_ready_i,
    input  icache_out_t       icache_data_i,
    input  logic              icache_data_valid_i,
    output logic              icache_data_ready_o,
    output logic [31:0]       instr_o,
    output logic [XLEN-1:0]   instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i
);
    localparam int OFF_W    = $clog2(ICACHE_INSTR);
    localparam int LINE_LSB = OFF_W + 2;
    localparam int PTR_W    = (LINE_BUF_DEPTH > 1) ? $clog2(LINE_BUF_DEPTH) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + LINE_BUF_DEPTH + 1) + 1;
    localparam logic [XLEN-1:0] LINE_BYTES = XLEN'(ICACHE_INSTR * 4);

    function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] a);
        return a & ~(LINE_BYTES - XLEN'(1));
    endfunction

    function automatic logic [OFF_W-1:0] line_off(input logic [XLEN-1:0] a);
        return a[LINE_LSB-1:2];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LINE_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic                          run_q;
    logic [XLEN-1:0]               fetch_addr_q, fetch_addr_d;
    logic [OFF_W-1:0]              start_idx_q, start_idx_d;
    logic [OFF_W-1:0]              rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]              outst_q, outst_d;
    logic [CNT_W-1:0]              drop_q, drop_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [ICACHE_INSTR-1:0][31:0] buf_line_q  [LINE_BUF_DEPTH];
    logic [XLEN-1:0]               buf_pc_q    [LINE_BUF_DEPTH];
    logic [OFF_W-1:0]              buf_start_q [LINE_BUF_DEPTH];

    logic             addr_valid_s, addr_hs_s, beat_s, beat_drop_s, push_s, buf_we_s;
    logic             instr_valid_s, instr_hs_s, pop_s;
    logic [OFF_W-1:0] cur_s;
    logic [CNT_W-1:0] drop_sum_s;

    // Credit rule: issue only while every live response is guaranteed a buffer slot.
    assign addr_valid_s  = run_q
                         && ((outst_q + drop_q) < CNT_W'(MAX_OUTSTANDING))
                         && ((outst_q + count_q) < CNT_W'(LINE_BUF_DEPTH));
    assign addr_hs_s     = addr_valid_s && icache_addr_ready_i;
    assign beat_s        = icache_data_valid_i && run_q;
    assign beat_drop_s   = beat_s && (drop_q != '0);
    assign push_s        = beat_s && (drop_q == '0) && (outst_q != '0);
    assign buf_we_s      = push_s && !flush_i;
    assign instr_valid_s = (count_q != '0);
    assign instr_hs_s    = instr_valid_s && instr_ready_i;
    assign cur_s         = (rd_idx_q == '0) ? buf_start_q[rd_ptr_q] : rd_idx_q;
    assign pop_s         = instr_hs_s && (cur_s == OFF_W'(ICACHE_INSTR - 1));
    assign drop_sum_s    = drop_q + outst_q + CNT_W'(addr_hs_s);

    assign icache_addr_o       = fetch_addr_q;
    assign icache_addr_valid_o = addr_valid_s;
    assign icache_data_ready_o = run_q;
    assign instr_valid_o       = instr_valid_s;

    // Present the head instruction; zero when the buffer is empty.
    always_comb begin
        instr_o    = 32'h0000_0000;
        instr_pc_o = '0;
        if (instr_valid_s) begin
            instr_o    = buf_line_q[rd_ptr_q][cur_s];
            instr_pc_o = buf_pc_q[rd_ptr_q] + XLEN'({cur_s, 2'b00});
        end else begin
            instr_o    = 32'h0000_0000;
            instr_pc_o = '0;
        end
    end

    // Next-state: flush overrides every same-cycle handshake.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        start_idx_d  = start_idx_q;
        rd_idx_d     = rd_idx_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (flush_i) begin
            fetch_addr_d = line_align(flush_pc_i);
            start_idx_d  = line_off(flush_pc_i);
            rd_idx_d     = '0;
            outst_d      = '0;
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            if (beat_s && (drop_sum_s != '0)) begin
                drop_d = drop_sum_s - CNT_W'(1);
            end else begin
                drop_d = drop_sum_s;
            end
        end else begin
            if (addr_hs_s) begin
                fetch_addr_d = fetch_addr_q + LINE_BYTES;
            end else begin
                fetch_addr_d = fetch_addr_q;
            end
            if (beat_drop_s) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
            if (push_s) begin
                start_idx_d = '0;
                wr_ptr_d    = ptr_inc(wr_ptr_q);
            end else begin
                start_idx_d = start_idx_q;
                wr_ptr_d    = wr_ptr_q;
            end
            if (pop_s) begin
                rd_idx_d = '0;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else if (instr_hs_s) begin
                rd_idx_d = cur_s + OFF_W'(1);
                rd_ptr_d = rd_ptr_q;
            end else begin
                rd_idx_d = rd_idx_q;
                rd_ptr_d = rd_ptr_q;
            end
            outst_d = outst_q + CNT_W'(addr_hs_s) - CNT_W'(push_s);
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Control state and line buffer storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q        <= 1'b0;
            fetch_addr_q <= line_align(BOOT_PC);
            start_idx_q  <= line_off(BOOT_PC);
            rd_idx_q     <= '0;
            outst_q      <= '0;
            drop_q       <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < LINE_BUF_DEPTH; i++) begin
                buf_line_q[i]  <= '0;
                buf_pc_q[i]    <= '0;
                buf_start_q[i] <= '0;
            end
        end else begin
            run_q        <= 1'b1;
            fetch_addr_q <= fetch_addr_d;
            start_idx_q  <= start_idx_d;
            rd_idx_q     <= rd_idx_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            if (buf_we_s) begin
                buf_line_q[wr_ptr_q]  <= icache_data_i.line;
                buf_pc_q[wr_ptr_q]    <= icache_data_i.pc;
                buf_start_q[wr_ptr_q] <= start_idx_q;
            end
        end
    end

    fetch_line_unit_chk #(
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .beat_i  (beat_s),
        .outst_i (outst_q),
        .drop_i  (drop_q)
    );
endmodule
